// File: rtl/bram_req_ctrl_pkg.sv
// Shared widths and depth for the BRAM request controller.
// Holds the default BRAM geometry and the response FIFO sizing used by the
// controller top, its response FIFO and the request/response interface.
package bram_req_ctrl_pkg;

  localparam int unsigned BRAM_ADDR_WIDTH = 10;
  localparam int unsigned BRAM_DATA_WIDTH = 8;
  localparam int unsigned RSP_FIFO_DEPTH  = 2;
  localparam int unsigned RSP_PTR_W       = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned RSP_CNT_W       = $clog2(RSP_FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_req_ctrl_if.sv
// Client-side request and response channels of the BRAM request controller.
// master: client (drives req_*, rsp_ready). slave: controller.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata                 : in-order read data channel
interface bram_req_ctrl_if
  import bram_req_ctrl_pkg::*;
#(
  parameter int unsigned addr_width = BRAM_ADDR_WIDTH,
  parameter int unsigned data_width = BRAM_DATA_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [addr_width-1:0] req_addr;
  logic [data_width-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [data_width-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/bram_req_ctrl_rsp_fifo.sv
// Small synchronous FIFO holding captured BRAM read data until the client takes it.
// Ports: clk, rst (sync, active-high), push/push_data, pop, count (occupancy),
// head (oldest entry, valid when count != 0).
module bram_req_ctrl_rsp_fifo
  import bram_req_ctrl_pkg::*;
#(
  parameter int unsigned data_width = BRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [RSP_CNT_W-1:0]  count,
  output logic [data_width-1:0] head
);

  logic [data_width-1:0] mem_q [RSP_FIFO_DEPTH];
  logic [data_width-1:0] mem_d [RSP_FIFO_DEPTH];
  logic [RSP_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RSP_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [RSP_CNT_W-1:0]  count_q, count_d;

  // Pointer/count update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + RSP_CNT_W'(push) - RSP_CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + RSP_PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + RSP_PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RSP_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_req_ctrl.sv
// Initiator-side controller for a single-port synchronous BRAM.
// Ports: clk, rst (sync, active-high); bus (slave modport: request and
// response channels); mem_we/mem_addr/mem_din to the BRAM, mem_dout from it
// (valid one cycle after the address). Reads return in order; writes are silent.
module bram_req_ctrl
  import bram_req_ctrl_pkg::*;
#(
  parameter int unsigned addr_width = BRAM_ADDR_WIDTH,
  parameter int unsigned data_width = BRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_req_ctrl_if.slave        bus,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_din,
  input  logic [data_width-1:0] mem_dout
);

  logic                  rd_inflight_q, rd_inflight_d;
  logic [RSP_CNT_W-1:0]  fifo_count;
  logic [data_width-1:0] fifo_head;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_empty;
  logic                  rsp_valid_c, rsp_pop_c, req_ready_c, req_fire_c;
  logic [2:0]            occ, occ_after_pop;

  // Credit check: a slot is free if outstanding reads minus this cycle's pop
  // leaves room. Uses only state and rsp_ready, never req_valid/req_we.
  // With an empty FIFO the BRAM output falls straight through to the client,
  // so a read popped on its data cycle never enters the FIFO.
  always_comb begin
    fifo_empty    = (fifo_count == '0);
    occ           = 3'(fifo_count) + 3'(rd_inflight_q);
    rsp_valid_c   = !fifo_empty || rd_inflight_q;
    rsp_pop_c     = rsp_valid_c && bus.rsp_ready;
    occ_after_pop = occ - 3'(rsp_pop_c);
    req_ready_c   = (occ_after_pop < 3'd2);
    req_fire_c    = bus.req_valid && req_ready_c;
    fifo_pop      = rsp_pop_c && !fifo_empty;
    fifo_push     = rd_inflight_q && !(rsp_pop_c && fifo_empty);
    rd_inflight_d = req_fire_c && !bus.req_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight_q <= 1'b0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
    end
  end

  bram_req_ctrl_rsp_fifo #(
    .data_width (data_width)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_dout),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // BRAM drive straight from the request channel; reset blocks a write.
  assign mem_addr = bus.req_addr;
  assign mem_din  = bus.req_wdata;
  assign mem_we   = req_fire_c && bus.req_we && !rst;

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  // Oldest data first; zero when nothing is pending.
  assign bus.rsp_rdata = !fifo_empty  ? fifo_head :
                         rd_inflight_q ? mem_dout  : '0;

endmodule
